// File: rtl/adbg_crc_pkg.sv
// adbg_crc_pkg: shared reflected CRC-32 constants and frame-checker state encoding
package adbg_crc_pkg;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CHECK, ST_DONE} state_e;
endpackage

// File: rtl/adbg_crc32_step.sv
// adbg_crc32_step: one-bit reflected CRC-32 update; crc/d in, crc_next out
module adbg_crc32_step
  import adbg_crc_pkg::*;
(
  input  logic [31:0] crc,
  input  logic        d,
  output logic [31:0] crc_next
);
  assign crc_next = {1'b0, crc[31:1]} ^ ((crc[0] ^ d) ? CRC_POLY_REFL : 32'h0);
endmodule

// File: rtl/adbg_crc32_check.sv
// adbg_crc32_check: serial frame CRC-32 checker
// ports: clk/rst_n, start+len begin a frame, bit_valid/bit_in serial bits,
// busy/done status, crc_ok/crc_err sticky verdict, crc_calc running CRC
module adbg_crc32_check
  import adbg_crc_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [31:0]      crc_calc
);
  state_e state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_step;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic mis_q, mis_d, ok_q, ok_d, err_q, err_d, bit_bad;
  adbg_crc32_step u_step (.crc(crc_q), .d(bit_in), .crc_next(crc_step));
  // CHECK counts 31 down to 0, so bit index k is the complement of the low five counter bits
  assign bit_bad = bit_in ^ crc_q[~cnt_q[4:0]];
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    cnt_d = cnt_q;
    mis_d = mis_q;
    ok_d = ok_q;
    err_d = err_q;
    if (start && state_q != ST_DONE) begin
      state_d = (len == '0) ? ST_CHECK : ST_DATA;
      crc_d = CRC_INIT;
      cnt_d = (len == '0) ? LEN_W'(31) : len;
      mis_d = 1'b0;
      ok_d = 1'b0;
      err_d = 1'b0;
    end else begin
      case (state_q)
        ST_DATA: if (bit_valid) begin
          crc_d = crc_step;
          state_d = (cnt_q == LEN_W'(1)) ? ST_CHECK : ST_DATA;
          cnt_d = (cnt_q == LEN_W'(1)) ? LEN_W'(31) : cnt_q - LEN_W'(1);
        end
        ST_CHECK: if (bit_valid) begin
          mis_d = mis_q | bit_bad;
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            // verdict is registered on entry to DONE so it is visible alongside done
            state_d = ST_DONE;
            ok_d = ~mis_d;
            err_d = mis_d;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      crc_q <= CRC_INIT;
      cnt_q <= '0;
      mis_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      ok_q <= ok_d;
      err_q <= err_d;
    end
  end
  assign busy = (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign done = state_q == ST_DONE;
  assign crc_ok = ok_q;
  assign crc_err = err_q;
  assign crc_calc = crc_q;
endmodule

// File: tb/tb_adbg_crc32_check.sv
// tb_adbg_crc32_check: directed table-driven bench for the serial CRC-32 checker
module tb_adbg_crc32_check;
  localparam int LW = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
  logic [LW-1:0] len = '0;
  logic busy, done, crc_ok, crc_err;
  logic [31:0] crc_calc;
  int total = 0, bad = 0;
  typedef struct {
    logic [15:0] len;
    logic [71:0] pay;
    logic [31:0] tx;
    logic [31:0] crc;
    logic        ok;
  } vec_t;
  vec_t v[7];
  always #5 clk = ~clk;
  adbg_crc32_check #(.LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bit_valid(bit_valid),
    .bit_in(bit_in), .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
    .crc_calc(crc_calc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Sends a frame starting at a negedge; stops early at bit index stop_at (>=0),
  // otherwise returns at the negedge where done must be visible.
  task automatic run_frame(input vec_t f, input int max_gap, input int stop_at);
    int n;
    n = int'(f.len) + 32;
    @(negedge clk);
    start = 1'b1;
    len = f.len;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("ok_cleared", {30'b0, crc_ok, crc_err}, 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) return;
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        chk("stall_no_done", {31'b0, done}, 32'd0);
        chk("stall_busy", {31'b0, busy}, 32'd1);
      end
      if (i == int'(f.len)) chk("crc_calc_in_check", crc_calc, f.crc);
      bit_valid = 1'b1;
      bit_in = (i < int'(f.len)) ? f.pay[i] : f.tx[i - int'(f.len)];
      @(negedge clk);
      bit_valid = 1'b0;
      if (i < n - 1) chk("no_early_done", {31'b0, done}, 32'd0);
    end
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("crc_ok", {31'b0, crc_ok}, {31'b0, f.ok});
    chk("crc_err", {31'b0, crc_err}, {31'b0, ~f.ok});
    chk("crc_held", crc_calc, f.crc);
  endtask
  task automatic after_done(input logic ok);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_not_busy", {31'b0, busy}, 32'd0);
    chk("verdict_held", {30'b0, crc_ok, crc_err}, {30'b0, ok, ~ok});
  endtask
  initial begin
    v[0] = '{16'd72, 72'h393837363534333231, 32'h340BC6D9, 32'h340BC6D9, 1'b1};
    v[1] = '{16'd72, 72'h393837363534333231, 32'h340BC6D9 ^ 32'h0002_0000, 32'h340BC6D9, 1'b0};
    v[2] = '{16'd0, 72'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    v[3] = '{16'd0, 72'h0, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    v[4] = '{16'd8, 72'h0, 32'h2DFD1072, 32'h2DFD1072, 1'b1};
    v[5] = '{16'd1, 72'h0, 32'h92477CDF, 32'h92477CDF, 1'b1};
    v[6] = '{16'd1, 72'h1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_verdict", {30'b0, crc_ok, crc_err}, 32'd0);
    chk("rst_crc", crc_calc, 32'hFFFFFFFF);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      run_frame(v[k], 0, -1);
      after_done(v[k].ok);
    end
    run_frame(v[0], 5, -1);
    after_done(1'b1);
    run_frame(v[0], 0, -1);
    start = 1'b1;
    len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", {31'b0, busy}, 32'd0);
    chk("start_in_done_ok_held", {31'b0, crc_ok}, 32'd1);
    chk("start_in_done_no_done", {31'b0, done}, 32'd0);
    run_frame(v[0], 0, 40);
    run_frame(v[0], 0, -1);
    after_done(1'b1);
    run_frame(v[1], 0, -1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_err", {31'b0, crc_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(v[0], 0, 82);
    chk("busy_before_rst", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_crc", crc_calc, 32'hFFFFFFFF);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_verdict", {30'b0, crc_ok, crc_err}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_no_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    run_frame(v[0], 0, -1);
    after_done(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
